// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_unit_pkg;

    // All-zero word decodes as sll $0,$0,0: architecturally a no-op.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_WAIT = 1'b1
    } fstate_e;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of hazard-unit controls, branch resolution, imem read and IF/ID outputs.
// Latency: n/a (wiring only).
// Backpressure: pc_write/ifid_write low holds the fetch stage.
// Ports: master = pipeline environment (hazard unit, resolver, imem);
//        slave  = fetch_unit.
interface fetch_unit_if #(
    parameter int CNT_W = 16
) ();
    logic             pc_write;
    logic             ifid_write;
    logic             branch_stall_n;
    logic             resolve_valid;
    logic             resolve_taken;
    logic [31:0]      resolve_target;
    logic [31:0]      imem_instr;
    logic [31:0]      pc;
    logic [31:0]      ifid_instr;
    logic [31:0]      ifid_pc4;
    logic             ifid_valid;
    logic             waiting;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output pc_write, ifid_write, branch_stall_n,
        output resolve_valid, resolve_taken, resolve_target, imem_instr,
        input  pc, ifid_instr, ifid_pc4, ifid_valid, waiting, bubble_count
    );

    modport slave (
        input  pc_write, ifid_write, branch_stall_n,
        input  resolve_valid, resolve_taken, resolve_target, imem_instr,
        output pc, ifid_instr, ifid_pc4, ifid_valid, waiting, bubble_count
    );
endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register with write-enable and bubble load.
// Latency: 1 cycle (d_i visible on q_o after the next rising edge).
// Backpressure: load_i low holds contents; bubble_i overrides load_i.
// Ports: clock, reset (async active-low), load_i, bubble_i, d_i -> q_o.
module fetch_unit_ifid_reg
    import fetch_unit_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  load_i,
    input  logic  bubble_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    ifid_t ifid_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ifid_q <= IFID_BUBBLE;
        end else if (bubble_i) begin
            ifid_q <= IFID_BUBBLE;
        end else if (load_i) begin
            ifid_q <= d_i;
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC, drives imem address, fills IF/ID, counts bubbles.
// Latency: word at pc lands in IF/ID one edge later; redirect takes effect at the next edge.
// Backpressure: pc_write/ifid_write low holds PC and IF/ID; branch stall parks in WAIT_RES.
// Ports: clock, reset (async active-low), fu_if (slave side of fetch_unit_if).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic        clock,
    input  logic        reset,
    fetch_unit_if.slave fu_if
);

    fstate_e          state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_plus4;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold;
    logic             ifid_load;
    logic             ifid_bubble;
    ifid_t            ifid_d, ifid_q;

    assign pc_plus4 = pc_q + 32'd4;   // modulo 2^32: 0xFFFF_FFFC wraps to 0
    assign hold     = !fu_if.pc_write || !fu_if.ifid_write;

    // State register (plus PC and bubble counter).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FS_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. A resolve pulse always returns to RUN, even with
    // no branch pending (treated as a flush-style redirect).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FS_RUN: begin
                if (fu_if.resolve_valid) begin
                    state_d = FS_RUN;
                end else if (!hold && !fu_if.branch_stall_n) begin
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (fu_if.resolve_valid) begin
                    state_d = FS_RUN;
                end
            end
            default: state_d = FS_RUN;
        endcase
    end

    // Output / datapath control. Redirect has top priority in both states;
    // in WAIT_RES the hazard inputs are ignored and a bubble goes in every cycle.
    always_comb begin
        pc_d        = pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (fu_if.resolve_valid) begin
            // Held PC is already the fall-through address; target forced word-aligned.
            pc_d        = fu_if.resolve_taken ? (fu_if.resolve_target & ~32'h3) : pc_q;
            ifid_bubble = 1'b1;
        end else if (state_q == FS_RUN) begin
            if (hold) begin
                pc_d = pc_q;
            end else if (!fu_if.branch_stall_n) begin
                ifid_bubble = 1'b1;
            end else begin
                pc_d      = pc_plus4;
                ifid_load = 1'b1;
            end
        end else begin
            ifid_bubble = 1'b1;
        end

        // Saturating bubble counter.
        cnt_d = cnt_q;
        if (ifid_bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ifid_d = '{instr: fu_if.imem_instr, pc4: pc_plus4, valid: 1'b1};

    fetch_unit_ifid_reg u_ifid_reg (
        .clock    (clock),
        .reset    (reset),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .d_i      (ifid_d),
        .q_o      (ifid_q)
    );

    assign fu_if.pc           = pc_q;
    assign fu_if.ifid_instr   = ifid_q.instr;
    assign fu_if.ifid_pc4     = ifid_q.pc4;
    assign fu_if.ifid_valid   = ifid_q.valid;
    assign fu_if.waiting      = (state_q == FS_WAIT);
    assign fu_if.bubble_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    typedef struct {
        logic        pw;
        logic        bsn;
        logic        rv;
        logic        rt;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_vld;
        logic        e_wait;
        logic [15:0] e_cnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fetch_unit_if #(.CNT_W(16)) bus ();
    fetch_unit_if #(.CNT_W(2))  wbus ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .fu_if (bus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut_wrap (
        .clock (clock),
        .reset (reset),
        .fu_if (wbus)
    );

    logic [31:0] imem [0:31];
    assign bus.imem_instr  = imem[bus.pc[6:2]];
    assign wbus.imem_instr = 32'h2000_00AA;

    int   errors = 0;
    int   checks = 0;
    vec_t tbl[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic pw, input logic bsn, input logic rv, input logic rt,
                                input logic [31:0] tgt, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic [31:0] e_pc4,
                                input logic e_vld, input logic e_wait, input logic [15:0] e_cnt);
        vec_t v;
        v.pw = pw; v.bsn = bsn; v.rv = rv; v.rt = rt; v.tgt = tgt;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4;
        v.e_vld = e_vld; v.e_wait = e_wait; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input vec_t v);
        if (which == 0) begin
            bus.pc_write = v.pw; bus.ifid_write = v.pw; bus.branch_stall_n = v.bsn;
            bus.resolve_valid = v.rv; bus.resolve_taken = v.rt; bus.resolve_target = v.tgt;
        end else begin
            wbus.pc_write = v.pw; wbus.ifid_write = v.pw; wbus.branch_stall_n = v.bsn;
            wbus.resolve_valid = v.rv; wbus.resolve_taken = v.rt; wbus.resolve_target = v.tgt;
        end
    endtask

    task automatic compare(input int which, input vec_t e, input string tag);
        if (which == 0) begin
            chk({tag, ".pc"},    bus.pc,                 e.e_pc);
            chk({tag, ".instr"}, bus.ifid_instr,         e.e_instr);
            chk({tag, ".pc4"},   bus.ifid_pc4,           e.e_pc4);
            chk({tag, ".valid"}, {31'h0, bus.ifid_valid}, {31'h0, e.e_vld});
            chk({tag, ".wait"},  {31'h0, bus.waiting},   {31'h0, e.e_wait});
            chk({tag, ".cnt"},   {16'h0, bus.bubble_count}, {16'h0, e.e_cnt});
        end else begin
            chk({tag, ".pc"},    wbus.pc,                 e.e_pc);
            chk({tag, ".instr"}, wbus.ifid_instr,         e.e_instr);
            chk({tag, ".pc4"},   wbus.ifid_pc4,           e.e_pc4);
            chk({tag, ".valid"}, {31'h0, wbus.ifid_valid}, {31'h0, e.e_vld});
            chk({tag, ".wait"},  {31'h0, wbus.waiting},   {31'h0, e.e_wait});
            chk({tag, ".cnt"},   {30'h0, wbus.bubble_count}, {16'h0, e.e_cnt});
        end
    endtask

    // Drive each row before an edge, push its expectation, pop and compare after the edge.
    task automatic run(input int which, input string tag);
        vec_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(which, tbl[i]);
            sb.push_back(tbl[i]);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            compare(which, e, $sformatf("%s[%0d]", tag, i));
        end
        tbl.delete();
    endtask

    task automatic idle();
        vec_t v;
        v = mk(1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
        drive(0, v);
        drive(1, v);
    endtask

    // Assert reset away from the edge, check both DUTs, release on a falling edge.
    task automatic apply_reset(input string tag);
        @(negedge clock);
        reset = 1'b0;
        idle();
        #2;
        compare(0, mk(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 16'h0), {tag, ".rst"});
        compare(1, mk(1, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0, 16'h0), {tag, ".rstw"});
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) imem[i] = 32'h2000_0000 + i;
        imem[0] = 32'h2008_0001;
        imem[1] = 32'h2009_0002;
        idle();

        // Sequential fetch, load-use stall, stall+redirect, spurious/unaligned redirect.
        apply_reset("A");
        //           pw bsn rv rt tgt            pc            instr          pc4          v  w  cnt
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h4,  32'h2008_0001, 32'h4,  1, 0, 16'd0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h8,  32'h2009_0002, 32'h8,  1, 0, 16'd0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,         32'h8,  32'h2009_0002, 32'h8,  1, 0, 16'd0));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,         32'h8,  32'h2009_0002, 32'h8,  1, 0, 16'd0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'hC,  32'h2000_0002, 32'hC,  1, 0, 16'd0));
        tbl.push_back(mk(0, 1, 1, 1, 32'h40,        32'h40, 32'h0,         32'h0,  0, 0, 16'd1));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h44, 32'h2000_0010, 32'h44, 1, 0, 16'd1));
        tbl.push_back(mk(1, 1, 1, 0, 32'h80,        32'h44, 32'h0,         32'h0,  0, 0, 16'd2));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h48, 32'h2000_0011, 32'h48, 1, 0, 16'd2));
        tbl.push_back(mk(1, 1, 1, 1, 32'h13,        32'h10, 32'h0,         32'h0,  0, 0, 16'd3));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h14, 32'h2000_0004, 32'h14, 1, 0, 16'd3));
        run(0, "A");

        // BEQ at pc=4, resolved taken to 0x20 two cycles after the stall.
        imem[1] = 32'h1109_0003;
        apply_reset("B");
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h4,  32'h2008_0001, 32'h4,  1, 0, 16'd0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h8,  32'h1109_0003, 32'h8,  1, 0, 16'd0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         32'h8,  32'h0,         32'h0,  0, 1, 16'd1));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         32'h8,  32'h0,         32'h0,  0, 1, 16'd2));
        tbl.push_back(mk(1, 1, 1, 1, 32'h20,        32'h20, 32'h0,         32'h0,  0, 0, 16'd3));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h24, 32'h2000_0008, 32'h24, 1, 0, 16'd3));
        run(0, "B");

        // Same branch resolved not-taken; pc_write low while waiting is ignored.
        apply_reset("C");
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h4,  32'h2008_0001, 32'h4,  1, 0, 16'd0));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h8,  32'h1109_0003, 32'h8,  1, 0, 16'd0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         32'h8,  32'h0,         32'h0,  0, 1, 16'd1));
        tbl.push_back(mk(0, 1, 0, 0, 32'h0,         32'h8,  32'h0,         32'h0,  0, 1, 16'd2));
        tbl.push_back(mk(1, 1, 1, 0, 32'h20,        32'h8,  32'h0,         32'h0,  0, 0, 16'd3));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'hC,  32'h2000_0002, 32'hC,  1, 0, 16'd3));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         32'hC,  32'h0,         32'h0,  0, 1, 16'd4));
        run(0, "C");

        // Reset asserted in WAIT_RES with a resolve pending: outputs clear with no clock edge.
        bus.resolve_valid  = 1'b1;
        bus.resolve_taken  = 1'b1;
        bus.resolve_target = 32'h60;
        @(negedge clock);
        reset = 1'b0;
        #1;
        compare(0, mk(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 16'h0), "D.async");
        idle();
        @(negedge clock);
        reset = 1'b1;
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h4,  32'h2008_0001, 32'h4,  1, 0, 16'd0));
        run(0, "D");

        // PC wrap from 0xFFFF_FFFC and 2-bit counter saturation.
        apply_reset("W");
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h0,  32'h2000_00AA, 32'h0,  1, 0, 16'd0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0,  32'h0,         32'h0,  0, 1, 16'd1));
        tbl.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0,  32'h0,         32'h0,  0, 1, 16'd2));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h0,  32'h0,         32'h0,  0, 1, 16'd3));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h0,  32'h0,         32'h0,  0, 1, 16'd3));
        tbl.push_back(mk(1, 1, 1, 0, 32'h0,         32'h0,  32'h0,         32'h0,  0, 0, 16'd3));
        tbl.push_back(mk(1, 1, 0, 0, 32'h0,         32'h4,  32'h2000_00AA, 32'h4,  1, 0, 16'd3));
        run(1, "W");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS pipeline. It owns the PC, drives the instruction-memory address, and captures the fetched word plus PC+4 into IF/ID for ID-stage decode and hazard detection. It obeys the load-use stall (PCwrite/IFID_write) and the control-hazard stall (BranchStall) from the ID-stage hazard unit. It redirects on branch/jump resolution from a later stage.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- CNT_W, 16: width of the bubble counter.

- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_write  in  1  from hazard unit; 0 = load-use stall, hold PC.
- ifid_write  in  1  from hazard unit; 0 = load-use stall, hold IF/ID.
- branch_stall_n  in  1  from hazard unit; 0 = IF/ID holds BEQ/BNE/J.
- resolve_valid  in  1  one-cycle pulse: outcome of the stalled branch/jump is available.
- resolve_taken  in  1  1 = redirect to resolve_target; valid with resolve_valid.
- resolve_target  in  32  redirect address, word-aligned.
- imem_instr  in  32  combinational instruction-memory read data at address pc.
- pc  out  32  current fetch address to instruction memory.
- ifid_instr  out  32  IF/ID instruction register.
- ifid_pc4  out  32  IF/ID PC+4 register.
- ifid_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
- waiting  out  1  1 while in WAIT_RES.
- bubble_count  out  CNT_W  saturating count of bubbles inserted.

## Operation
- Two-state FSM: RUN, WAIT_RES. Reset state is RUN.
- In RUN, the first matching rule applies:
  - resolve_valid=1: apply the redirect (see below). Do not load IF/ID.
  - pc_write=0 or ifid_write=0: hold PC and IF/ID unchanged. pc_write and ifid_write are always driven equal.
  - branch_stall_n=0: hold PC. Load bubble into IF/ID (instr=0, pc4=0, valid=0). Go to WAIT_RES.
  - Otherwise: PC <= PC+4; IF/ID <= {imem_instr, PC+4, valid=1}.
- Redirect:
  - PC <= resolve_taken ? resolve_target : PC. The held PC is already the fall-through address.
  - Load bubble into IF/ID. Go to RUN.
- In WAIT_RES:
  - Hold PC.
  - Load bubble into IF/ID every cycle.
  - Ignore pc_write, ifid_write and branch_stall_n.
  - On resolve_valid=1, apply the redirect.
- resolve_valid in RUN with no branch pending is still honoured, as a mispredict/exception-style redirect with IF/ID flush.
- A bubble is all-zero. It decodes as sll $0,$0,0 with no architectural effect.
- bubble_count increments by 1 on every cycle that loads a bubble into IF/ID. It saturates at all-ones and never wraps.
- PC+4 uses 32-bit modulo arithmetic; 32'hFFFF_FFFC wraps to 0.
- resolve_target[1:0] is ignored; the PC is forced word-aligned.

## Timing
- Reset (asynchronous assert, synchronous-clock release):
  - pc=RESET_PC; ifid_instr=0; ifid_pc4=0; ifid_valid=0; waiting=0; bubble_count=0; state=RUN.
  - First fetch happens on the first rising edge after release.
- Fetch latency: the word at pc appears in IF/ID one edge later.
- Branch in IF/ID at edge N:
  - branch_stall_n is seen low before edge N+1.
  - Edge N+1: bubble loaded, waiting=1.
  - Each later edge without resolve_valid adds one bubble.
- Resolve pulse before edge M: pc is the correct target after edge M, and that instruction reaches IF/ID at edge M+1.
- Reset asserted mid-WAIT_RES: immediate return to the reset values. A pending resolve is discarded.

## Structure
- Shared constants go in constants.h: bubble encoding `NOP_INSTR (32'h0), and the state encodings `FS_RUN / `FS_WAIT.
- RESET_PC stays a module parameter.
- One natural sub-module: ifid_reg, the IF/ID register with write-enable, bubble-load and async active-low reset. The FSM, PC and counter stay in fetch_unit.

## Test plan
- Reset release, no stalls, imem returns 0x20080001, 0x20090002:
  - pc goes 0, 4, 8.
  - ifid_pc4 is 4 then 8, ifid_valid=1, bubble_count stays 0.
- pc_write=ifid_write=0 for 2 cycles at pc=8: pc and IF/ID unchanged for 2 edges, then resume with pc=12.
- BEQ (0x1109_0003) at pc=4, branch_stall_n low, resolve pulse with taken=1, target=0x20 two cycles later:
  - pc held at 8.
  - 3 bubbles; bubble_count=3.
  - Next pc=0x20 and waiting=0.
- Same case with taken=0: pc resumes at 8, the instruction at 8 enters IF/ID after the bubbles.
- Stall and redirect in the same cycle (pc_write=0 with resolve_valid=1, taken, 0x40): redirect wins, pc=0x40, IF/ID is a bubble.
- Counter and wrap edge cases:
  - Force bubble_count to 16'hFFFF: it saturates.
  - Sequential fetch at RESET_PC=32'hFFFF_FFFC: pc wraps to 0.
  - Reset asserted in WAIT_RES: all outputs reach their reset values without a clock edge.
